awg_playback_sequencer: RTL and testbench

AWG_PLAYBACK_SEQUENCER -- requirements
Module: awg_playback_sequencer

---
 rtl/awg_playback_sequencer_if.sv | 13 +
 rtl/awg_playback_sequencer.sv | 141 ++++++++++++++
 tb/tb_awg_playback_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/awg_playback_sequencer_if.sv
// BRAM read-side bundle of the AWG playback sequencer: word address, read strobe,
// half-word select and sample-valid, all time-aligned to the BRAM/composer pipeline.
interface awg_playback_sequencer_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_en;
  logic                  odd;
  logic                  sample_valid;

  modport master (output bram_addr, bram_en, odd, sample_valid);
  modport slave  (input  bram_addr, bram_en, odd, sample_valid);
endinterface

// File: rtl/awg_playback_sequencer.sv
// Plays a sample table out of a two-samples-per-word BRAM at a programmable
// decimated rate, either one-shot or looping, with arm/trigger/stop control.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for arm; config may be (re)loaded
// S_ARMED | config latched, waiting for trigger
// S_RUN   | issuing one BRAM read per sample period
// S_DONE  | one-shot playback finished; config may be (re)loaded
module awg_playback_sequencer #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH:0]   num_samples,
  input  logic [15:0]           decimation,
  awg_playback_sequencer_if.master bram,
  output logic                  armed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wrap_count,
  output logic                  cfg_error
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] num_q;
  logic [ADDR_WIDTH:0] index_q;
  logic [15:0]         dec_q;
  logic [15:0]         div_q;
  logic                loop_q;
  logic                odd_q;
  logic                done_q;
  logic                cfg_err_q;
  logic [1:0]          vld_pipe_q;
  logic [15:0]         wrap_q;

  logic cfg_state;
  logic accept_arm;
  logic reject_arm;
  logic tick;
  logic last;
  logic finish;

  assign cfg_state  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_arm = !stop && cfg_state && arm && (num_samples != '0);
  assign reject_arm = !stop && cfg_state && arm && (num_samples == '0);
  // stop suppresses the strobe in its own cycle so no read is issued while aborting
  assign tick       = !stop && (state_q == S_RUN) && (div_q == 16'd0);
  assign last       = (index_q == (num_q - IDX_ONE));
  assign finish     = tick && last && !loop_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (accept_arm) state_d = S_ARMED;
        S_ARMED:        if (trigger)    state_d = S_RUN;
        S_RUN:          if (finish)     state_d = S_DONE;
        default:                        state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      num_q      <= '0;
      dec_q      <= '0;
      loop_q     <= 1'b0;
      index_q    <= '0;
      div_q      <= '0;
      odd_q      <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      vld_pipe_q <= '0;
      wrap_q     <= '0;
    end else begin
      done_q     <= finish;
      vld_pipe_q <= stop ? 2'b00 : {vld_pipe_q[0], tick};
      if (tick) odd_q <= index_q[0];

      if (accept_arm) begin
        num_q     <= num_samples;
        dec_q     <= decimation;
        loop_q    <= loop_en;
        wrap_q    <= '0;
        cfg_err_q <= 1'b0;
      end else if (reject_arm) begin
        cfg_err_q <= 1'b1;
      end

      if (stop) begin
        index_q <= '0;
        div_q   <= '0;
      end else if ((state_q == S_ARMED) && trigger) begin
        index_q <= '0;
        div_q   <= '0;
      end else if (state_q == S_RUN) begin
        if (tick) begin
          div_q <= dec_q;
          if (last) begin
            index_q <= '0;
            if (loop_q && (wrap_q != 16'hFFFF)) wrap_q <= wrap_q + 16'd1;
          end else begin
            index_q <= index_q + IDX_ONE;
          end
        end else begin
          div_q <= div_q - 16'd1;
        end
      end
    end
  end

  assign bram.bram_en      = tick;
  assign bram.bram_addr    = index_q[ADDR_WIDTH:1];
  assign bram.odd          = odd_q;
  assign bram.sample_valid = vld_pipe_q[1];
  assign armed             = (state_q == S_ARMED);
  assign busy              = (state_q == S_RUN);
  assign done              = done_q;
  assign wrap_count        = wrap_q;
  assign cfg_error         = cfg_err_q;

endmodule

// File: tb/tb_awg_playback_sequencer.sv
// Bench for awg_playback_sequencer: config table, closed-form timing model for
// random runs, and hand sequences for stop, reset and wrap saturation.
module tb_awg_playback_sequencer;
  localparam int AW = 13;
  localparam int NW = AW + 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          arm, trigger, stop, loop_en;
  logic [AW:0]   num_samples;
  logic [15:0]   decimation;
  logic          armed, busy, done, cfg_error;
  logic [15:0]   wrap_count;

  int checks = 0;
  int errors = 0;

  awg_playback_sequencer_if #(.ADDR_WIDTH(AW)) bif ();

  awg_playback_sequencer #(.ADDR_WIDTH(AW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .arm         (arm),
    .trigger     (trigger),
    .stop        (stop),
    .loop_en     (loop_en),
    .num_samples (num_samples),
    .decimation  (decimation),
    .bram        (bif.master),
    .armed       (armed),
    .busy        (busy),
    .done        (done),
    .wrap_count  (wrap_count),
    .cfg_error   (cfg_error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int num;
    int dec;
    bit lp;
    int run;
    bit exp_armed;
    bit exp_cfg_err;
    int exp_ticks;
    int exp_dones;
    int exp_wrap;
    bit exp_busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic arm_cfg(input int num, input int dec, input bit lp);
    num_samples = NW'(num);
    decimation  = 16'(dec);
    loop_en     = lp;
    arm         = 1'b1;
    @(posedge aclk); #1;
    arm         = 1'b0;
  endtask

  task automatic trig();
    trigger = 1'b1;
    @(posedge aclk); #1;
    trigger = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(posedge aclk); #1;
    stop = 1'b0;
  endtask

  // Tick in run-relative cycle c: one every P = dec+1 cycles from c = 0
  function automatic bit exp_tick(input int c, input int p, input int num, input bit lp);
    return (c >= 0) && (c % p == 0) && (lp || (c / p < num));
  endfunction

  task automatic run_check(input int num, input int dec, input bit lp, input int cycles, input bit noise);
    int p, kl, nt, ewrap;
    bit et;
    p = dec + 1;
    stop_pulse();
    arm_cfg(num, dec, lp);
    chk("armed_after_arm", armed, 1);
    trig();
    for (int c = 0; c < cycles; c++) begin
      @(negedge aclk);
      et = exp_tick(c, p, num, lp);
      chk("bram_en", bif.bram_en, et);
      if (et) chk("bram_addr", bif.bram_addr, ((c / p) % num) >> 1);
      if (c >= 1) begin
        kl = (c - 1) / p;
        if (!lp && kl > num - 1) kl = num - 1;
        chk("odd", bif.odd, (kl % num) & 1);
      end
      chk("sample_valid", bif.sample_valid, exp_tick(c - 2, p, num, lp));
      chk("busy", busy, lp || (c <= (num - 1) * p));
      chk("done", done, !lp && (c == (num - 1) * p + 1));
      chk("armed_run", armed, 0);
      nt = (c == 0) ? 0 : (c - 1) / p + 1;
      if (!lp && nt > num) nt = num;
      ewrap = lp ? nt / num : 0;
      chk("wrap_count", wrap_count, ewrap);
      @(posedge aclk); #1;
      if (noise) begin
        arm         = 1'($urandom_range(0, 1));
        num_samples = NW'($urandom_range(0, 20));
        decimation  = 16'($urandom_range(0, 5));
        loop_en     = 1'($urandom_range(0, 1));
      end
    end
    arm = 1'b0;
    chk("cfg_error_run", cfg_error, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int ticks, dones;
    vecs[0] = '{num:4, dec:0, lp:0, run:10, exp_armed:1, exp_cfg_err:0, exp_ticks:4, exp_dones:1, exp_wrap:0, exp_busy:0};
    vecs[1] = '{num:3, dec:2, lp:1, run:21, exp_armed:1, exp_cfg_err:0, exp_ticks:7, exp_dones:0, exp_wrap:2, exp_busy:1};
    vecs[2] = '{num:0, dec:0, lp:0, run:0,  exp_armed:0, exp_cfg_err:1, exp_ticks:0, exp_dones:0, exp_wrap:0, exp_busy:0};
    vecs[3] = '{num:2, dec:0, lp:0, run:6,  exp_armed:1, exp_cfg_err:0, exp_ticks:2, exp_dones:1, exp_wrap:0, exp_busy:0};
    vecs[4] = '{num:5, dec:1, lp:0, run:20, exp_armed:1, exp_cfg_err:0, exp_ticks:5, exp_dones:1, exp_wrap:0, exp_busy:0};
    vecs[5] = '{num:1, dec:3, lp:1, run:9,  exp_armed:1, exp_cfg_err:0, exp_ticks:3, exp_dones:0, exp_wrap:3, exp_busy:1};
    vecs[6] = '{num:7, dec:0, lp:1, run:15, exp_armed:1, exp_cfg_err:0, exp_ticks:15, exp_dones:0, exp_wrap:2, exp_busy:1};

    aresetn = 1'b0; arm = 0; trigger = 0; stop = 0; loop_en = 0;
    num_samples = '0; decimation = '0;
    @(posedge aclk); #1;
    chk("rst_bram_en", bif.bram_en, 0);
    chk("rst_bram_addr", bif.bram_addr, 0);
    chk("rst_odd", bif.odd, 0);
    chk("rst_sample_valid", bif.sample_valid, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap_count, 0);
    chk("rst_cfg_error", cfg_error, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Configuration table
    foreach (vecs[i]) begin
      stop_pulse();
      arm_cfg(vecs[i].num, vecs[i].dec, vecs[i].lp);
      chk($sformatf("v%0d_armed", i), armed, vecs[i].exp_armed);
      chk($sformatf("v%0d_cfg_error", i), cfg_error, vecs[i].exp_cfg_err);
      if (vecs[i].exp_armed) begin
        trig();
        ticks = 0; dones = 0;
        for (int c = 0; c < vecs[i].run; c++) begin
          @(negedge aclk);
          if (bif.bram_en) ticks++;
          if (done) dones++;
          @(posedge aclk); #1;
        end
        chk($sformatf("v%0d_ticks", i), ticks, vecs[i].exp_ticks);
        chk($sformatf("v%0d_dones", i), dones, vecs[i].exp_dones);
        chk($sformatf("v%0d_wrap", i), wrap_count, vecs[i].exp_wrap);
        chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      end
    end

    // Exact waveforms for the reference cases, then random runs
    run_check(4, 0, 0, 10, 0);
    run_check(3, 2, 1, 24, 0);
    for (int r = 0; r < 8; r++) begin
      int n, d;
      bit l;
      n = $urandom_range(1, 9);
      d = $urandom_range(0, 3);
      l = 1'($urandom_range(0, 1));
      run_check(n, d, l, 40, l);
    end

    // stop coinciding with a tick
    stop_pulse();
    arm_cfg(8, 0, 1);
    trig();
    repeat (3) begin @(posedge aclk); #1; end
    stop_pulse();
    chk("stop_busy", busy, 0);
    chk("stop_armed", armed, 0);
    chk("stop_sv_next", bif.sample_valid, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("stop_bram_en", bif.bram_en, 0);
      chk("stop_sv", bif.sample_valid, 0);
      @(posedge aclk); #1;
    end

    // stop beats trigger, stop beats arm
    arm_cfg(4, 0, 0);
    chk("pre_trig_armed", armed, 1);
    trigger = 1'b1; stop = 1'b1;
    @(posedge aclk); #1;
    trigger = 1'b0; stop = 1'b0;
    chk("stop_vs_trig_busy", busy, 0);
    chk("stop_vs_trig_armed", armed, 0);
    num_samples = '0; arm = 1'b1; stop = 1'b1;
    @(posedge aclk); #1;
    chk("stop_vs_arm0_cfg_error", cfg_error, 0);
    num_samples = NW'(3);
    @(posedge aclk); #1;
    arm = 1'b0; stop = 1'b0;
    chk("stop_vs_arm_armed", armed, 0);

    // Reset mid-run
    arm_cfg(5, 1, 1);
    trig();
    repeat (7) begin @(posedge aclk); #1; end
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_bram_en", bif.bram_en, 0);
    chk("mid_rst_sv", bif.sample_valid, 0);
    chk("mid_rst_odd", bif.odd, 0);
    chk("mid_rst_addr", bif.bram_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wrap", wrap_count, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    trigger = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("post_rst_bram_en", bif.bram_en, 0);
      chk("post_rst_sv", bif.sample_valid, 0);
      chk("post_rst_busy", busy, 0);
      @(posedge aclk); #1;
    end
    trigger = 1'b0;

    // Wrap counter saturation
    arm_cfg(1, 0, 1);
    trig();
    repeat (70000) @(posedge aclk);
    #1;
    chk("sat_wrap", wrap_count, 16'hFFFF);
    chk("sat_busy", busy, 1);
    @(posedge aclk); #1;
    chk("sat_wrap_hold", wrap_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
